// File: rtl/ram_sp_initiator.sv
// Master-side sequencer for a single-port RAM. It accepts single-word writes and
// 1..4-word read bursts, and it owns all RAM pin timing.
module ram_sp_initiator #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  wr_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_add,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_r_w,
  output logic                  ram_enable,
  output logic                  ram_ce,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_DATA  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [LEN_WIDTH-1:0]  r_beats_left;
  logic                  r_wr_done;

  logic w_accept;
  logic w_rd_handshake;
  logic w_last_beat;

  assign w_last_beat    = (r_beats_left == '0);
  assign w_accept       = req_valid & req_ready;
  assign w_rd_handshake = rst_n & ce & (r_state == S_RD_DATA) & rd_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = req_we ? S_WRITE : S_RD_ISSUE;
      end
      S_WRITE:    w_next_state = S_IDLE;
      S_RD_ISSUE: w_next_state = S_RD_DATA;
      S_RD_DATA: begin
        if (rd_ready) w_next_state = w_last_beat ? S_IDLE : S_RD_ISSUE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_beats_left <= '0;
      r_wr_done    <= 1'b0;
    end else if (ce) begin
      r_wr_done <= (r_state == S_WRITE);
      if (w_accept) begin
        r_addr <= req_addr;
        if (req_we) begin
          r_wdata <= req_wdata;
        end else begin
          r_beats_left <= req_len;
        end
      end else if (w_rd_handshake && !w_last_beat) begin
        // Address wraps modulo 2**ADDR_WIDTH through natural overflow.
        r_addr       <= r_addr + ADDR_WIDTH'(1);
        r_beats_left <= r_beats_left - LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    busy        = 1'b0;
    ram_add     = '0;
    ram_data_in = '0;
    ram_r_w     = 1'b0;
    ram_enable  = 1'b0;
    if (rst_n) begin
      busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: req_ready = ce;
        S_WRITE: begin
          ram_enable  = 1'b1;
          ram_r_w     = 1'b1;
          ram_add     = r_addr;
          ram_data_in = r_wdata;
        end
        S_RD_ISSUE: begin
          ram_enable = 1'b1;
          ram_add    = r_addr;
        end
        S_RD_DATA: begin
          rd_valid = 1'b1;
          rd_last  = w_last_beat;
          ram_add  = r_addr;
        end
        default: ;
      endcase
    end
  end

  // The RAM output register holds read data, so no local copy is kept.
  assign rd_data = ram_data_out;
  assign wr_done = r_wr_done & ce & rst_n;
  assign ram_ce  = ce;

endmodule

// File: tb/tb_ram_sp_initiator.sv
// Directed bench for ram_sp_initiator with a behavioural registered-output RAM.
module tb_ram_sp_initiator;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int LW = 2;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_wdata;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          wr_done;
  logic          busy;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_data_in;
  logic          ram_r_w;
  logic          ram_enable;
  logic          ram_ce;
  logic [DW-1:0] ram_data_out = '0;

  logic [DW-1:0] ram_mem [64] = '{default: '0};
  logic [DW-1:0] exp_mem [64];
  int            en_count = 0;
  int            n_checks;
  int            n_fail;
  int            snap;

  ram_sp_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .wr_done(wr_done), .busy(busy),
    .ram_add(ram_add), .ram_data_in(ram_data_in), .ram_r_w(ram_r_w),
    .ram_enable(ram_enable), .ram_ce(ram_ce), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read data, frozen when ram_ce is low.
  always @(posedge clk) begin
    if (ram_ce && ram_enable) begin
      en_count <= en_count + 1;
      if (ram_r_w) ram_mem[ram_add] <= ram_data_in;
      else         ram_data_out     <= ram_mem[ram_add];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    check("wr_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0; req_we = 1'b0;
    check("wr_enable", ram_enable, 1);
    check("wr_r_w", ram_r_w, 1);
    check("wr_add", ram_add, a);
    check("wr_data_in", ram_data_in, d);
    check("wr_busy_ready", {busy, req_ready, wr_done}, 3'b100);
    step();
    check("wr_done_pulse", wr_done, 1);
    check("wr_idle", {busy, ram_enable, ram_r_w}, 3'b000);
    check("wr_mem", ram_mem[a], d);
    exp_mem[a] = d;
    step();
    check("wr_done_end", wr_done, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len);
    logic [AW-1:0] ad;
    rd_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len;
    check("rd_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ad = a + AW'(i);
      check("rd_issue_en", {ram_enable, ram_r_w, rd_valid, req_ready}, 4'b1000);
      check("rd_issue_add", ram_add, ad);
      check("rd_din_zero", ram_data_in, 0);
      step();
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, exp_mem[ad]);
      check("rd_last", rd_last, (i == int'(len)) ? 1 : 0);
      check("rd_data_en", ram_enable, 0);
      step();
    end
    check("rd_done_idle", {busy, rd_valid, req_ready}, 3'b001);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    rst_n = 1'b0; ce = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    req_addr = '0; req_len = '0; req_wdata = '0; rd_ready = 1'b1;
    #1;

    // Reset held three cycles with a request pending.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outputs", {req_ready, ram_enable, rd_valid, busy, wr_done}, 5'b00000);
      check("rst_add", ram_add, 0);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", req_ready, 1);
    check("rst_no_access", en_count, 0);
    step();

    // Write then single-word read back.
    do_write(6'd5, 16'hA5C3);
    do_read(6'd5, 2'd0);
    check("rd_a5c3_value", exp_mem[5], 16'hA5C3);

    // Burst crossing the top of the address space.
    do_write(6'd62, 16'd1);
    do_write(6'd63, 16'd2);
    do_write(6'd0,  16'd3);
    do_write(6'd1,  16'd4);
    do_read(6'd62, 2'd3);

    // Backpressure on beat 0 of a two-beat burst.
    do_write(6'd10, 16'h1111);
    do_write(6'd11, 16'h2222);
    rd_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd10; req_len = 2'd1;
    step();
    req_valid = 1'b0;
    check("bp_issue_add", ram_add, 10);
    step();
    check("bp_beat0", {rd_valid, rd_last}, 2'b10);
    check("bp_beat0_data", rd_data, 16'h1111);
    snap = en_count;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", {rd_valid, ram_enable}, 2'b10);
      check("bp_hold_data", rd_data, 16'h1111);
    end
    check("bp_no_access", en_count, snap);
    rd_ready = 1'b1;
    step();
    check("bp_beat1_issue", {ram_enable, ram_r_w}, 2'b10);
    check("bp_beat1_add", ram_add, 11);
    step();
    check("bp_beat1", {rd_valid, rd_last}, 2'b11);
    check("bp_beat1_data", rd_data, 16'h2222);
    step();
    check("bp_idle", busy, 0);

    // Clock-enable low in IDLE blocks acceptance.
    ce = 1'b0;
    #1;
    check("ce_idle_ready", {req_ready, ram_ce}, 2'b00);
    ce = 1'b1;
    #1;

    // Clock-enable low while in RD_DATA.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5; req_len = 2'd0;
    step();
    req_valid = 1'b0;
    step();
    ce = 1'b0;
    #1;
    check("ce_rd_ram_ce", ram_ce, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ce_rd_frozen", {rd_valid, rd_last, busy, req_ready}, 4'b1110);
      check("ce_rd_data", rd_data, 16'hA5C3);
    end
    ce = 1'b1;
    step();
    check("ce_rd_resume", {busy, rd_valid, req_ready}, 3'b001);

    // Clock-enable low while in WRITE.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd20; req_wdata = 16'hBEEF;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    ce = 1'b0;
    snap = en_count;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ce_wr_frozen", {wr_done, busy, ram_ce, ram_r_w}, 4'b0101);
      check("ce_wr_mem_old", ram_mem[20], 0);
    end
    check("ce_wr_no_access", en_count, snap);
    ce = 1'b1;
    step();
    check("ce_wr_done", {wr_done, busy}, 2'b10);
    check("ce_wr_mem", ram_mem[20], 16'hBEEF);
    exp_mem[20] = 16'hBEEF;
    step();
    check("ce_wr_done_end", wr_done, 0);
    do_read(6'd20, 2'd0);

    // Reset during beat 2 of a four-beat burst.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd62; req_len = 2'd3;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_beat2_issue_add", ram_add, 0);
    step();
    check("mid_beat2_data", rd_data, 16'd3);
    check("mid_beat2_valid", {rd_valid, rd_last}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    snap = en_count;
    step();
    check("mid_rst_idle", {busy, rd_valid, ram_enable}, 3'b000);
    step();
    check("mid_rst_hold", {busy, ram_enable}, 2'b00);
    rst_n = 1'b1;
    #1;
    check("mid_rst_release", req_ready, 1);
    step();
    check("mid_no_access", en_count, snap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
